// File: rtl/dmr_handshake_join.sv
// Joins NUM_IN lockstep valid/ready sources into one destination handshake,
// flagging valid/data disagreement and forwarding one copy through a one-entry register.
module dmr_handshake_join #(
  parameter type T = logic,
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                error_before_i,
  input  logic                error_after_i,
  output logic                error_o,
  output logic [CntWidth-1:0] err_cnt_o,
  input  logic [NUM_IN-1:0]   valid_i,
  output logic [NUM_IN-1:0]   ready_o,
  input  T [NUM_IN-1:0]       data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output T                    data_o
);

  logic                full_q, full_d;
  T                    data_q, data_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic all_valid;
  logic any_valid;
  logic data_mismatch;
  logic mismatch;
  logic accept;
  logic commit;
  logic drain;

  // Source agreement: valids must be unanimous; data only matters when all are valid.
  always_comb begin
    all_valid     = &valid_i;
    any_valid     = |valid_i;
    data_mismatch = 1'b0;
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      if (data_i[k] != data_i[0]) data_mismatch = 1'b1;
    end
    mismatch = (all_valid ^ any_valid) | (all_valid & data_mismatch);
  end

  // error_after_i is kept out of accept so ready_o has no path from it.
  always_comb begin
    accept = all_valid & ~mismatch & ~error_before_i & (~full_q | ready_i);
    commit = accept & ~error_after_i;
    drain  = full_q & ready_i;
  end

  // Next-state: buffer fill/drain, payload capture and saturating error count.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (!enable_i) begin
      full_d = 1'b0;
    end else begin
      if (commit) begin
        full_d = 1'b1;
        data_d = data_i[0];
      end else if (drain) begin
        full_d = 1'b0;
      end
      if (mismatch && (cnt_q != {CntWidth{1'b1}})) begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // Bypass mode passes source 0 straight through.
  always_comb begin
    err_cnt_o = cnt_q;
    if (enable_i) begin
      error_o = mismatch;
      ready_o = {NUM_IN{accept}};
      valid_o = full_q;
      data_o  = data_q;
    end else begin
      error_o    = 1'b0;
      ready_o    = '0;
      ready_o[0] = ready_i;
      valid_o    = valid_i[0];
      data_o     = data_i[0];
    end
  end

endmodule

// File: tb/tb_dmr_handshake_join.sv
// Bench for dmr_handshake_join: directed vector table, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_dmr_handshake_join;

  typedef logic [7:0] byte_t;

  logic             clk;
  logic             rst;
  logic             en, eb, ea;
  logic [1:0]       v_in;
  byte_t [1:0]      d_in;
  logic             rdy_in;

  logic             err, err_s;
  logic [7:0]       cnt;
  logic [1:0]       cnt_s;
  logic [1:0]       rdy_o, rdy_s;
  logic             vo, vo_s;
  byte_t            dout, dout_s;

  int n_cmp = 0;
  int n_bad = 0;

  dmr_handshake_join #(.T(byte_t), .NUM_IN(2), .CntWidth(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .error_before_i(eb), .error_after_i(ea),
    .error_o(err), .err_cnt_o(cnt), .valid_i(v_in), .ready_o(rdy_o), .data_i(d_in),
    .valid_o(vo), .ready_i(rdy_in), .data_o(dout)
  );

  dmr_handshake_join #(.T(byte_t), .NUM_IN(2), .CntWidth(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .error_before_i(eb), .error_after_i(ea),
    .error_o(err_s), .err_cnt_o(cnt_s), .valid_i(v_in), .ready_o(rdy_s), .data_i(d_in),
    .valid_o(vo_s), .ready_i(rdy_in), .data_o(dout_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: output buffer as a queue of at most one word, unbounded error tally.
  byte_t buf_q[$];
  byte_t mlast;
  int    mcnt;

  function automatic logic m_err();
    if (!en) return 1'b0;
    if (v_in != 2'b00 && v_in != 2'b11) return 1'b1;
    if (v_in == 2'b11 && d_in[1] != d_in[0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_acc();
    return en && (v_in == 2'b11) && !m_err() && !eb && (buf_q.size() == 0 || rdy_in);
  endfunction

  task automatic check_model();
    logic [1:0] exp_rdy;
    exp_rdy = en ? {2{m_acc()}} : {1'b0, rdy_in};
    chk("error_o", int'(err), int'(m_err()));
    chk("ready_o", int'(rdy_o), int'(exp_rdy));
    chk("valid_o", int'(vo), en ? int'(buf_q.size() != 0) : int'(v_in[0]));
    chk("data_o", int'(dout), en ? int'(buf_q.size() != 0 ? buf_q[0] : mlast) : int'(d_in[0]));
    chk("err_cnt", int'(cnt), (mcnt > 255) ? 255 : mcnt);
    chk("err_cnt_sat", int'(cnt_s), (mcnt > 3) ? 3 : mcnt);
    chk("valid_o_sat", int'(vo_s), int'(vo));
  endtask

  task automatic update_model();
    logic a, e;
    if (en) begin
      a = m_acc();
      e = m_err();
      if (buf_q.size() != 0 && rdy_in) void'(buf_q.pop_front());
      if (a && !ea) begin
        buf_q.push_back(d_in[0]);
        mlast = d_in[0];
      end
      if (e) mcnt++;
    end else begin
      buf_q.delete();
    end
  endtask

  task automatic drive(input logic e_en, input logic e_eb, input logic e_ea, input logic [1:0] v,
                       input byte_t d1, input byte_t d0, input logic r);
    en = e_en; eb = e_eb; ea = e_ea; v_in = v; d_in[1] = d1; d_in[0] = d0; rdy_in = r;
  endtask

  task automatic step();
    #1;
    check_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en, eb, ea;
    logic [1:0] v;
    byte_t      d1, d0;
    logic       rdy;
    logic       evo;
    byte_t      edo;
    logic [1:0] ero;
    logic       eerr;
    byte_t      ecnt;
  } vec_t;

  vec_t tbl[21];

  initial begin
    //            en  eb  ea  v      d1     d0     rdy  evo  edo    ero    eerr ecnt
    tbl[0]  = '{1'b1,1'b0,1'b0,2'b11,8'hA5,8'hA5,1'b1,1'b0,8'h00,2'b11,1'b0,8'd0};
    tbl[1]  = '{1'b1,1'b0,1'b0,2'b11,8'h01,8'h01,1'b1,1'b1,8'hA5,2'b11,1'b0,8'd0};
    tbl[2]  = '{1'b1,1'b0,1'b0,2'b11,8'h02,8'h02,1'b1,1'b1,8'h01,2'b11,1'b0,8'd0};
    tbl[3]  = '{1'b1,1'b0,1'b0,2'b11,8'h03,8'h03,1'b1,1'b1,8'h02,2'b11,1'b0,8'd0};
    tbl[4]  = '{1'b1,1'b0,1'b0,2'b11,8'h04,8'h04,1'b1,1'b1,8'h03,2'b11,1'b0,8'd0};
    tbl[5]  = '{1'b1,1'b0,1'b0,2'b00,8'h00,8'h00,1'b1,1'b1,8'h04,2'b00,1'b0,8'd0};
    tbl[6]  = '{1'b1,1'b0,1'b0,2'b11,8'h11,8'h10,1'b1,1'b0,8'h04,2'b00,1'b1,8'd0};
    tbl[7]  = '{1'b1,1'b0,1'b0,2'b11,8'h11,8'h11,1'b1,1'b0,8'h04,2'b11,1'b0,8'd1};
    tbl[8]  = '{1'b1,1'b0,1'b0,2'b01,8'h00,8'h00,1'b1,1'b1,8'h11,2'b00,1'b1,8'd1};
    tbl[9]  = '{1'b1,1'b0,1'b1,2'b11,8'h55,8'h55,1'b1,1'b0,8'h11,2'b11,1'b0,8'd2};
    tbl[10] = '{1'b1,1'b0,1'b0,2'b11,8'h55,8'h55,1'b1,1'b0,8'h11,2'b11,1'b0,8'd2};
    tbl[11] = '{1'b1,1'b1,1'b0,2'b11,8'h66,8'h66,1'b1,1'b1,8'h55,2'b00,1'b0,8'd2};
    tbl[12] = '{1'b1,1'b0,1'b0,2'b11,8'h22,8'h22,1'b0,1'b0,8'h55,2'b11,1'b0,8'd2};
    tbl[13] = '{1'b1,1'b0,1'b0,2'b11,8'h33,8'h33,1'b0,1'b1,8'h22,2'b00,1'b0,8'd2};
    tbl[14] = '{1'b1,1'b0,1'b0,2'b11,8'h33,8'h33,1'b1,1'b1,8'h22,2'b11,1'b0,8'd2};
    tbl[15] = '{1'b1,1'b0,1'b0,2'b00,8'h00,8'h00,1'b1,1'b1,8'h33,2'b00,1'b0,8'd2};
    tbl[16] = '{1'b0,1'b0,1'b0,2'b01,8'h00,8'h7E,1'b1,1'b1,8'h7E,2'b01,1'b0,8'd2};
    tbl[17] = '{1'b0,1'b1,1'b1,2'b01,8'h00,8'h7E,1'b0,1'b1,8'h7E,2'b00,1'b0,8'd2};
    tbl[18] = '{1'b1,1'b0,1'b0,2'b00,8'h00,8'h00,1'b1,1'b0,8'h33,2'b00,1'b0,8'd2};
    tbl[19] = '{1'b1,1'b1,1'b0,2'b10,8'h00,8'h00,1'b1,1'b0,8'h33,2'b00,1'b1,8'd2};
    tbl[20] = '{1'b1,1'b0,1'b0,2'b00,8'h00,8'h00,1'b1,1'b0,8'h33,2'b00,1'b0,8'd3};

    mlast = '0;
    mcnt  = 0;
    rst   = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    #3;
    chk("reset_valid_o", int'(vo), 0);
    chk("reset_data_o", int'(dout), 0);
    chk("reset_err_cnt", int'(cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors with hand-derived expectations
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].en, tbl[i].eb, tbl[i].ea, tbl[i].v, tbl[i].d1, tbl[i].d0, tbl[i].rdy);
      #1;
      chk($sformatf("tbl%0d_valid_o", i), int'(vo), int'(tbl[i].evo));
      chk($sformatf("tbl%0d_data_o", i), int'(dout), int'(tbl[i].edo));
      chk($sformatf("tbl%0d_ready_o", i), int'(rdy_o), int'(tbl[i].ero));
      chk($sformatf("tbl%0d_error_o", i), int'(err), int'(tbl[i].eerr));
      chk($sformatf("tbl%0d_err_cnt", i), int'(cnt), int'(tbl[i].ecnt));
      step();
    end

    // Saturation: five more mismatch cycles; narrow counter pinned at 3
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'b11, 8'h40, 8'h41, 1'b1);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    #1;
    chk("sat_cnt_narrow", int'(cnt_s), 3);
    chk("sat_cnt_wide", int'(cnt), 8);
    step();

    // Asynchronous reset while the buffer holds a word
    drive(1'b1, 1'b0, 1'b0, 2'b11, 8'h99, 8'h99, 1'b0);
    step();
    chk("pre_reset_valid_o", int'(vo), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_valid_o", int'(vo), 0);
    chk("async_reset_data_o", int'(dout), 0);
    chk("async_reset_err_cnt", int'(cnt), 0);
    chk("async_reset_err_cnt_sat", int'(cnt_s), 0);
    chk("async_reset_ready_o", int'(rdy_o), 2'b11);
    @(posedge clk);
    #1 rst = 1'b0;
    buf_q.delete();
    mlast = '0;
    mcnt  = 0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [1:0] v;
      byte_t d0, d1;
      int r;
      r  = int'($urandom_range(0, 7));
      v  = (r < 5) ? 2'b11 : 2'(r - 5);
      d0 = byte_t'($urandom);
      d1 = ($urandom_range(0, 5) == 0) ? byte_t'($urandom) : d0;
      drive($urandom_range(0, 15) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
            v, d1, d0, $urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
